// File: rtl/ysyx_22050612_ifu_fetch_if.sv
// Bus bundle between the fetch unit and its environment: instruction memory
// request/response, decode handoff, redirect and halt.
interface ysyx_22050612_ifu_fetch_if;
  logic        halt;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [63:0] mem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    input  halt, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           redirect_valid, redirect_pc, inst_ready,
    output mem_req_valid, mem_req_addr, mem_rsp_ready,
           inst_valid, inst, inst_pc
  );

  modport slave (
    output halt, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           redirect_valid, redirect_pc, inst_ready,
    input  mem_req_valid, mem_req_addr, mem_rsp_ready,
           inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ysyx_22050612_ifu_fetch.sv
// Instruction fetch: owns the PC, fetches one aligned doubleword at a time and
// hands the selected 32-bit word to decode; supports redirect and halt.
module ysyx_22050612_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_22050612_ifu_fetch_if.master        bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] pc_r;
  logic [31:0] inst_r;
  logic [63:0] inst_pc_r;

  logic        req_valid_s;
  logic        rsp_ready_s;
  logic        inst_valid_s;
  logic        req_fire_s;
  logic        rsp_fire_s;
  logic [63:0] redirect_target_s;

  assign req_fire_s        = req_valid_s & bus.mem_req_ready;
  assign rsp_fire_s        = rsp_ready_s & bus.mem_rsp_valid;
  assign redirect_target_s = {bus.redirect_pc[63:2], 2'b00};

  assign bus.mem_req_valid = req_valid_s;
  assign bus.mem_rsp_ready = rsp_ready_s;
  assign bus.inst_valid    = inst_valid_s;
  assign bus.mem_req_addr  = {pc_r[63:3], 3'b000};
  assign bus.inst          = inst_r;
  assign bus.inst_pc       = inst_pc_r;

  // Handshake strobes decoded from the state register, held low during reset.
  always_comb begin
    req_valid_s  = 1'b0;
    rsp_ready_s  = 1'b0;
    inst_valid_s = 1'b0;
    if (rst) begin
      req_valid_s  = 1'b0;
      rsp_ready_s  = 1'b0;
      inst_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_REQ:  req_valid_s  = ~bus.halt;
        ST_WAIT: rsp_ready_s  = 1'b1;
        ST_HOLD: inst_valid_s = 1'b1;
        ST_DROP: rsp_ready_s  = 1'b1;
        default: begin
          req_valid_s  = 1'b0;
          rsp_ready_s  = 1'b0;
          inst_valid_s = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM, PC and instruction registers; redirect outranks every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_REQ;
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      inst_pc_r <= 64'd0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (bus.redirect_valid) begin
            pc_r    <= redirect_target_s;
            state_r <= req_fire_s ? ST_DROP : ST_REQ;
          end else if (req_fire_s) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_valid) begin
            pc_r    <= redirect_target_s;
            state_r <= rsp_fire_s ? ST_REQ : ST_DROP;
          end else if (rsp_fire_s) begin
            inst_r    <= pc_r[2] ? bus.mem_rsp_data[63:32] : bus.mem_rsp_data[31:0];
            inst_pc_r <= pc_r;
            pc_r      <= pc_r + 64'd4;
            state_r   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.redirect_valid) begin
            pc_r    <= redirect_target_s;
            state_r <= ST_REQ;
          end else if (bus.inst_ready) begin
            state_r <= ST_REQ;
          end
        end
        ST_DROP: begin
          // A stale response is swallowed here; redirect only updates the PC.
          if (bus.redirect_valid) begin
            pc_r <= redirect_target_s;
          end
          if (rsp_fire_s) begin
            state_r <= ST_REQ;
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050612_ifu_fetch.md
# ysyx_22050612_ifu_fetch

Instruction fetch unit that produces the 32-bit instruction word the decode stage consumes. It owns the PC, issues 64-bit aligned read requests to instruction memory over a valid/ready handshake, extracts the addressed 32-bit half, and presents it with its PC to decode over a second valid/ready handshake. It sits between the instruction-memory port and the decoder. It supports redirects from branch/jump resolution, including discarding an in-flight fetch, and a halt input used after ebreak.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  level; while 1, no new memory request is issued.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  64  {pc[63:3],3'b000}.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_ready  out  1  unit accepts read data.
- mem_rsp_data  in  64  read doubleword.
- redirect_valid  in  1  one-cycle pulse: replace PC.
- redirect_pc  in  64  new PC; bits [1:0] ignored (forced 0).
- inst_valid  out  1  instruction held for decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  64  PC of inst.

## Operation
- Registers: pc (64), state, inst (32), inst_pc (64).
- States: REQ, WAIT, HOLD, DROP.
- REQ: mem_req_valid = !halt. On mem_req_valid && mem_req_ready -> WAIT.
- WAIT: mem_rsp_ready = 1. On mem_rsp_valid: inst <= pc[2] ? data[63:32] : data[31:0]; inst_pc <= pc; pc <= pc + 4 (64-bit wrap, no carry out). -> HOLD.
- HOLD: inst_valid = 1; inst/inst_pc stable. On inst_ready -> REQ.
- DROP: mem_rsp_ready = 1. On mem_rsp_valid the data is discarded -> REQ.
- Outputs mem_req_valid, mem_rsp_ready and inst_valid are 0 in every other state.
- Redirect has priority over all other events in the same cycle. It sets pc <= {redirect_pc[63:2],2'b00} and affects the state as follows:
  - REQ, request not accepted this cycle: stay REQ.
  - REQ, request accepted the same cycle: -> DROP.
  - WAIT, no response this cycle: -> DROP.
  - WAIT, response this cycle: the data is discarded -> REQ.
  - HOLD: the held instruction is discarded, no handshake counts even if inst_ready = 1 -> REQ.
  - DROP: stay DROP. If the response arrives the same cycle -> REQ.
- halt only gates new requests. An outstanding WAIT/HOLD completes normally. Deasserting halt resumes from the current pc.

## Timing
- Reset (async assert): pc = RESET_PC, state = REQ, inst = 0, inst_pc = 0.
- While rst = 1, all valid/ready outputs are forced 0.
- mem_req_addr always reflects the current pc (aligned).
- First request is asserted in the first cycle after rst deasserts, provided halt = 0.
- Best-case latency: request accepted at cycle N, response at N+1, inst_valid at N+2, next request at N+3 if inst_ready is held at 1. Throughput is 1 instruction per 3 cycles, with no overlap.
- Memory response latency is unbounded; the unit waits in WAIT/DROP indefinitely.
- Exactly one request is outstanding at a time. A response is never accepted in REQ or HOLD.
- Reset mid-transaction: returns to REQ immediately and the pending response is not tracked. The memory side must also be reset.

## Test plan
- Reset then fetch: rst pulse, memory returns 64'h00000013_00100093 at addr 0x80000000. Required: inst = 0x00100093 with inst_pc = 0x80000000, then the next request at addr 0x80000000 returns inst = 0x00000013 with inst_pc = 0x80000004.
- Backpressure: inst_ready held 0 for 5 cycles in HOLD. Required: inst_valid stays 1, inst and inst_pc are unchanged, mem_req_valid = 0, and the next request is issued one cycle after the inst_ready handshake.
- Redirect in WAIT: redirect_pc = 0x80000100 while the response for 0x80000008 is pending. Required: that response is dropped, never presented; the next request addr = 0x80000100; the next inst_pc = 0x80000100.
- Redirect in HOLD with inst_ready = 1 the same cycle. Required: no handshake, inst_valid = 0 next cycle, and the next fetch comes from the redirect target.
- Redirect on the same cycle the request is accepted, with redirect_pc = 0x80000206. Required: the response is discarded via DROP, and the next inst_pc = 0x80000204.
- Halt: assert halt in REQ for 10 cycles. Required: mem_req_valid = 0 throughout; after halt deasserts, the request resumes at the same pc. A halt asserted in WAIT still lets that instruction reach HOLD.
